// File: rtl/weight_stream_ram.sv
// Row-wide weight RAM: word-serial loader fills one row at a time, stream sweeps all rows.
// Optional macro WEIGHT_RAM_FWD_EN forwards a same-cycle commit to the read port.
module weight_stream_ram #(
  parameter int NROW = 16,
  parameter int NCOL = 16,
  parameter int BITWIDTH = 18,
  localparam int ADDR_BITWIDTH = (NCOL > 1) ? $clog2(NCOL) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       loadStart,
  input  logic [BITWIDTH-1:0]        wordIn,
  input  logic                       wordValid,
  output logic                       wordReady,
  output logic                       loadDone,
  input  logic                       streamStart,
  output logic                       streamBusy,
  output logic [NROW*BITWIDTH-1:0]   rowOut,
  output logic                       rowValid,
  output logic [ADDR_BITWIDTH-1:0]   rowAddr,
  output logic                       rowLast,
  output logic [1:0]                 dbg_load_state,
  output logic                       dbg_stream_state
);

  localparam int ROW_W = NROW * BITWIDTH;
  localparam int CNT_W = (NROW > 1) ? $clog2(NROW) : 1;
  localparam logic [ADDR_BITWIDTH-1:0] LAST_ADDR = ADDR_BITWIDTH'(NCOL - 1);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NROW - 1);

  typedef enum logic [1:0] {L_IDLE, L_FILL, L_COMMIT} load_state_t;
  typedef enum logic {S_IDLE, S_STREAM} stream_state_t;

  load_state_t                load_state;
  logic [CNT_W-1:0]           word_cnt;
  logic [ADDR_BITWIDTH-1:0]   wr_addr;
  logic [ROW_W-1:0]           row_buf;
  logic                       load_done_q;
  logic                       commit;

  stream_state_t              stream_state;
  logic [ADDR_BITWIDTH-1:0]   rd_addr;
  logic                       issue;
  logic [ROW_W-1:0]           read_data;
  logic [ROW_W-1:0]           row_out_q;
  logic [ADDR_BITWIDTH-1:0]   row_addr_q;
  logic                       row_valid_q;
  logic                       row_last_q;

  logic [ROW_W-1:0]           mem [NCOL];

  // Handshake: a word transfers on a rising edge where wordValid && wordReady;
  // wordIn must hold while wordValid is high and wordReady is low.
  assign wordReady = (load_state == L_FILL);
  assign commit    = (load_state == L_COMMIT);
  assign loadDone  = load_done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      load_state  <= L_IDLE;
      word_cnt    <= '0;
      wr_addr     <= '0;
      row_buf     <= '0;
      load_done_q <= 1'b0;
    end else begin
      load_done_q <= 1'b0;
      case (load_state)
        L_IDLE: begin
          if (loadStart) begin
            load_state <= L_FILL;
            word_cnt   <= '0;
            wr_addr    <= '0;
          end
        end
        L_FILL: begin
          if (wordValid) begin
            row_buf[word_cnt*BITWIDTH +: BITWIDTH] <= wordIn;
            if (word_cnt == LAST_WORD) begin
              load_state <= L_COMMIT;
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end
        end
        L_COMMIT: begin
          word_cnt <= '0;
          if (wr_addr == LAST_ADDR) begin
            load_state  <= L_IDLE;
            load_done_q <= 1'b1;
          end else begin
            wr_addr    <= wr_addr + 1'b1;
            load_state <= L_FILL;
          end
        end
        default: load_state <= L_IDLE;
      endcase
    end
  end

  // RAM contents survive reset; only the write port is gated by the loader.
  always_ff @(posedge clk) begin
    if (commit) begin
      mem[wr_addr] <= row_buf;
    end
  end

  assign issue = (stream_state == S_STREAM);

  // The drain cycle (last row on the output, FSM already idle) still counts as busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      stream_state <= S_IDLE;
      rd_addr      <= '0;
    end else begin
      case (stream_state)
        S_IDLE: begin
          if (streamStart && !row_valid_q) begin
            stream_state <= S_STREAM;
            rd_addr      <= '0;
          end
        end
        S_STREAM: begin
          if (rd_addr == LAST_ADDR) begin
            stream_state <= S_IDLE;
          end else begin
            rd_addr <= rd_addr + 1'b1;
          end
        end
        default: stream_state <= S_IDLE;
      endcase
    end
  end

`ifdef WEIGHT_RAM_FWD_EN
  assign read_data = (commit && (wr_addr == rd_addr)) ? row_buf : mem[rd_addr];
`else
  assign read_data = mem[rd_addr];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      row_out_q   <= '0;
      row_addr_q  <= '0;
      row_valid_q <= 1'b0;
      row_last_q  <= 1'b0;
    end else begin
      row_valid_q <= issue;
      row_last_q  <= issue && (rd_addr == LAST_ADDR);
      if (issue) begin
        row_out_q  <= read_data;
        row_addr_q <= rd_addr;
      end
    end
  end

  assign rowOut     = row_out_q;
  assign rowAddr    = row_addr_q;
  assign rowValid   = row_valid_q;
  assign rowLast    = row_last_q;
  assign streamBusy = issue || row_valid_q;

  assign dbg_load_state   = load_state;
  assign dbg_stream_state = stream_state;

endmodule
